// File: rtl/ws2812_pkg.sv
// Shared WS2812 line definitions: receiver state encoding, pixel width and default 12 MHz timing.
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } rx_state_e;

    localparam int GRB_W = 24;

    localparam int NUM_LEDS_DEF      = 64;
    localparam int BIT_THRESHOLD_DEF = 8;    // ~0.67 us at 12 MHz
    localparam int HIGH_MAX_DEF      = 24;   // 2.0 us at 12 MHz
    localparam int LATCH_CYCLES_DEF  = 600;  // 50 us at 12 MHz

endpackage

// File: rtl/ws2812_din_sync.sv
// Brings the asynchronous WS2812 line into the clk domain and reports its level and edges.
module ws2812_din_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            prev_q <= sync_q[1];
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~prev_q;
    assign fall  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/ws2812_line_decoder.sv
// WS2812 line receiver: classifies high pulses, assembles GRB pixels and detects frame latches.
// Optional WS2812_RX_STATS_EN adds frame_count / error_count statistics outputs.
module ws2812_line_decoder
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS      = NUM_LEDS_DEF,
    parameter int BIT_THRESHOLD = BIT_THRESHOLD_DEF,
    parameter int HIGH_MAX      = HIGH_MAX_DEF,
    parameter int LATCH_CYCLES  = LATCH_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din,
    output logic [GRB_W-1:0]            pixel_data,
    output logic [$clog2(NUM_LEDS)-1:0] pixel_index,
    output logic                        pixel_valid,
    output logic                        frame_done,
    output logic [$clog2(NUM_LEDS):0]   frame_pixels,
    output logic                        error,
    output logic                        busy
`ifdef WS2812_RX_STATS_EN
    ,
    output logic [15:0]                 frame_count,
    output logic [7:0]                  error_count
`endif
);

    localparam int IDX_W  = $clog2(NUM_LEDS);
    localparam int HCNT_W = $clog2(HIGH_MAX + 2);
    localparam int LCNT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [HCNT_W-1:0] HCNT_SAT   = HCNT_W'(HIGH_MAX + 1);
    localparam logic [HCNT_W-1:0] HCNT_BIT1  = HCNT_W'(BIT_THRESHOLD);
    localparam logic [LCNT_W-1:0] LCNT_LATCH = LCNT_W'(LATCH_CYCLES);
    localparam logic [IDX_W:0]    PIX_MAX    = (IDX_W + 1)'(NUM_LEDS);

    logic level, rise, fall;

    ws2812_din_sync u_din_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_e         state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [GRB_W-2:0]  shreg_q, shreg_d;
    logic [IDX_W:0]    pix_cnt_q, pix_cnt_d;
    logic              ovf_q, ovf_d;

    logic [GRB_W-1:0]  pixel_data_d;
    logic [IDX_W-1:0]  pixel_index_d;
    logic [IDX_W:0]    frame_pixels_d;
    logic              pixel_valid_d, frame_done_d, error_d, busy_d;
    logic              bit_val;
    logic [GRB_W-1:0]  pixel_word;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
        state_d        = state_q;
        hcnt_d         = hcnt_q;
        lcnt_d         = lcnt_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        pix_cnt_d      = pix_cnt_q;
        ovf_d          = ovf_q;
        pixel_data_d   = pixel_data;
        pixel_index_d  = pixel_index;
        frame_pixels_d = frame_pixels;
        pixel_valid_d  = 1'b0;
        frame_done_d   = 1'b0;
        error_d        = 1'b0;
        bit_val        = (hcnt_q >= HCNT_BIT1);
        pixel_word     = {shreg_q, bit_val};

        case (state_q)
            SYNC: begin
                // Only a full latch-length low proves we are between frames.
                bit_cnt_d = '0;
                pix_cnt_d = '0;
                ovf_d     = 1'b0;
                if (level) begin
                    lcnt_d = '0;
                end else if (lcnt_q == LCNT_LATCH) begin
                    state_d = IDLE;
                    lcnt_d  = '0;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = HCNT_W'(1);
                end
            end
            HIGH: begin
                if (hcnt_q == HCNT_SAT) begin
                    error_d = 1'b1;
                    state_d = SYNC;
                    lcnt_d  = '0;
                end else if (fall) begin
                    state_d = LOW;
                    lcnt_d  = LCNT_W'(1);
                    shreg_d = pixel_word[GRB_W-2:0];
                    if (bit_cnt_q == 5'(GRB_W - 1)) begin
                        bit_cnt_d = '0;
                        if (pix_cnt_q < PIX_MAX) begin
                            pixel_valid_d = 1'b1;
                            pixel_data_d  = pixel_word;
                            pixel_index_d = pix_cnt_q[IDX_W-1:0];
                            pix_cnt_d     = pix_cnt_q + 1'b1;
                        end else if (!ovf_q) begin
                            error_d = 1'b1;
                            ovf_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = HCNT_W'(1);
                end else if (lcnt_q == LCNT_LATCH) begin
                    // LOW is only entered after a bit, so every latch here closes a real frame.
                    state_d        = IDLE;
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pix_cnt_q;
                    error_d        = (bit_cnt_q != '0);
                    bit_cnt_d      = '0;
                    pix_cnt_d      = '0;
                    ovf_d          = 1'b0;
                    lcnt_d         = '0;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase

        busy_d = (state_d == HIGH) || (state_d == LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SYNC;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            pix_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            pixel_data   <= '0;
            pixel_index  <= '0;
            frame_pixels <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            lcnt_q       <= lcnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            pix_cnt_q    <= pix_cnt_d;
            ovf_q        <= ovf_d;
            pixel_data   <= pixel_data_d;
            pixel_index  <= pixel_index_d;
            frame_pixels <= frame_pixels_d;
            pixel_valid  <= pixel_valid_d;
            frame_done   <= frame_done_d;
            error        <= error_d;
            busy         <= busy_d;
        end
    end

`ifdef WS2812_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            error_count <= '0;
        end else begin
            if (frame_done_d) begin
                frame_count <= frame_count + 1'b1;
            end
            if (error_d && (error_count != 8'hFF)) begin
                error_count <= error_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_line_decoder.sv
// Self-checking bench for ws2812_line_decoder: pulse-level stimulus checked against a bit-stream model.
module tb_ws2812_line_decoder;

    localparam int NUM_LEDS = 64;
    localparam int IDX_W    = 6;
    localparam int BT       = 8;
    localparam int HM       = 24;
    localparam int LC       = 600;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              din = 1'b0;
    logic [23:0]       pixel_data;
    logic [IDX_W-1:0]  pixel_index;
    logic              pixel_valid, frame_done, error, busy;
    logic [IDX_W:0]    frame_pixels;
`ifdef WS2812_RX_STATS_EN
    logic [15:0]       frame_count;
    logic [7:0]        error_count;
`endif

    ws2812_line_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_index  (pixel_index),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .error        (error),
        .busy         (busy)
`ifdef WS2812_RX_STATS_EN
        ,
        .frame_count  (frame_count),
        .error_count  (error_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int hi;
        int lo;
    } pulse_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [23:0]      data;
    } pix_t;

    pulse_t      plan[$];
    logic [23:0] exp_pix[$];
    pix_t        got_pix[$];
    int          got_fpix[$];
    bit          got_fderr[$];
    int          got_err;
    int          coincide;
    int          exp_frames, exp_fpix, exp_err;
    bit          exp_fderr;

    always @(negedge clk) begin
        if (pixel_valid === 1'b1) got_pix.push_back('{pixel_index, pixel_data});
        if (frame_done === 1'b1) begin
            got_fpix.push_back(int'(frame_pixels));
            got_fderr.push_back(error);
        end
        if (error === 1'b1) got_err++;
        if (pixel_valid === 1'b1 && frame_done === 1'b1) coincide++;
    end

    // Each level is held for exactly n sampling edges; callers always sit 1 time unit after a posedge.
    task automatic drive(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void clear_all();
        plan.delete();
        exp_pix.delete();
        got_pix.delete();
        got_fpix.delete();
        got_fderr.delete();
        got_err    = 0;
        exp_frames = 0;
        exp_fpix   = 0;
        exp_err    = 0;
        exp_fderr  = 1'b0;
    endfunction

    task automatic add_bit(input bit b, input bit rnd);
        pulse_t p;
        if (rnd) begin
            p.hi = b ? int'($urandom_range(HM, BT)) : int'($urandom_range(BT - 1, 1));
            p.lo = int'($urandom_range(20, 1));
        end else begin
            p.hi = b ? 10 : 4;
            p.lo = b ? 5 : 11;
        end
        plan.push_back(p);
    endtask

    task automatic add_pixel(input logic [23:0] px, input bit rnd);
        for (int i = 23; i >= 0; i--) add_bit(px[i], rnd);
    endtask

    task automatic run_range(input int from, input int to, input bit latch);
        for (int i = from; i < to; i++) begin
            drive(1'b1, plan[i].hi);
            drive(1'b0, plan[i].lo);
        end
        if (latch) drive(1'b0, LC + 20);
    endtask

    // Reference: classify each pulse by its length, group bits in 24s, apply the frame rules.
    function automatic void model_plan();
        int          nbits = 0;
        int          npix = 0;
        logic [23:0] acc = '0;
        bit          ovf = 1'b0;
        bit          aborted = 1'b0;
        foreach (plan[i]) begin
            if (!aborted) begin
                if (plan[i].hi > HM) begin
                    exp_err++;
                    aborted = 1'b1;
                end else begin
                    acc = 24'((acc * 2) + ((plan[i].hi >= BT) ? 1 : 0));
                    nbits++;
                    if (nbits % 24 == 0) begin
                        if (npix < NUM_LEDS) begin
                            exp_pix.push_back(acc);
                            npix++;
                        end else if (!ovf) begin
                            exp_err++;
                            ovf = 1'b1;
                        end
                    end
                end
            end
        end
        if (!aborted && nbits > 0) begin
            exp_frames = 1;
            exp_fpix   = npix;
            if (nbits % 24 != 0) begin
                exp_err++;
                exp_fderr = 1'b1;
            end
        end
    endfunction

    function automatic int pix_mismatch();
        int m = 0;
        if (got_pix.size() != exp_pix.size()) m++;
        for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
            if (got_pix[i].data !== exp_pix[i] || int'(got_pix[i].idx) != i) m++;
        end
        return m;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 3);
        checks++;
        if (pixel_data !== 24'h0 || pixel_index !== '0 || frame_pixels !== '0) begin
            failures++;
            $display("FAIL reset_data: data=%h idx=%0d fpix=%0d, required all 0", pixel_data, pixel_index, frame_pixels);
        end
        checks++;
        if (pixel_valid !== 1'b0 || frame_done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: valid=%b done=%b err=%b busy=%b, required 0", pixel_valid, frame_done, error, busy);
        end
`ifdef WS2812_RX_STATS_EN
        checks++;
        if (frame_count !== 16'h0 || error_count !== 8'h0) begin
            failures++;
            $display("FAIL reset_stats: frames=%0d errors=%0d, required 0", frame_count, error_count);
        end
`endif
        rst_n = 1'b1;
        drive(1'b0, LC + 20);
    endtask

    task automatic test_single_pixel();
        clear_all();
        add_pixel(24'hFF0000, 1'b0);
        run_range(0, 23, 1'b0);
        drive(1'b1, plan[23].hi);
        din = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (pixel_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_early: valid=%b two clocks after fall, required 0", pixel_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (pixel_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL valid_latency: valid=%b busy=%b three clocks after fall, required 1 1", pixel_valid, busy);
        end
        drive(1'b0, LC + 20);
        model_plan();
        checks++;
        if (pix_mismatch() != 0) begin
            failures++;
            $display("FAIL single_pixels: got %0d pixels (first %h), required %0d (%h)", got_pix.size(),
                     (got_pix.size() > 0) ? got_pix[0].data : 24'h0, exp_pix.size(), exp_pix[0]);
        end
        checks++;
        if (got_fpix.size() != 1 || (got_fpix.size() == 1 && got_fpix[0] != exp_fpix)) begin
            failures++;
            $display("FAIL single_frame: got %0d frame strobes, required 1 with %0d pixels", got_fpix.size(), exp_fpix);
        end
        checks++;
        if (busy !== 1'b0 || got_err != exp_err) begin
            failures++;
            $display("FAIL single_idle: busy=%b errors=%0d, required 0 %0d", busy, got_err, exp_err);
        end
    endtask

    task automatic test_three_pixels();
        clear_all();
        add_pixel(24'h00FF00, 1'b0);
        add_pixel(24'h0000FF, 1'b0);
        add_pixel(24'hA5A5A5, 1'b0);
        run_range(0, plan.size(), 1'b1);
        model_plan();
        checks++;
        if (pix_mismatch() != 0) begin
            failures++;
            $display("FAIL three_pixels: got %0d pixels, %0d mismatched, required %0d", got_pix.size(), pix_mismatch(), exp_pix.size());
        end
        checks++;
        if (got_fpix.size() != exp_frames || (got_fpix.size() == 1 && got_fpix[0] != exp_fpix)) begin
            failures++;
            $display("FAIL three_frame: got %0d strobes, required %0d with %0d pixels", got_fpix.size(), exp_frames, exp_fpix);
        end
    endtask

    task automatic test_random_frames();
        coincide = 0;
        for (int f = 0; f < 3; f++) begin
            clear_all();
            for (int p = 0; p < int'($urandom_range(6, 1)); p++) add_pixel(24'($urandom), 1'b1);
            run_range(0, plan.size(), 1'b1);
            model_plan();
            checks++;
            if (pix_mismatch() != 0) begin
                failures++;
                $display("FAIL random_pixels[%0d]: got %0d pixels, %0d mismatched, required %0d", f, got_pix.size(), pix_mismatch(), exp_pix.size());
            end
            checks++;
            if (got_fpix.size() != exp_frames || (got_fpix.size() == 1 && got_fpix[0] != exp_fpix)) begin
                failures++;
                $display("FAIL random_frame[%0d]: got %0d strobes, required %0d with %0d pixels", f, got_fpix.size(), exp_frames, exp_fpix);
            end
            checks++;
            if (got_err != exp_err) begin
                failures++;
                $display("FAIL random_errors[%0d]: got %0d, required %0d", f, got_err, exp_err);
            end
        end
        checks++;
        if (coincide != 0) begin
            failures++;
            $display("FAIL valid_done_overlap: %0d cycles with both strobes, required 0", coincide);
        end
    endtask

    task automatic test_partial_bits();
        clear_all();
        add_pixel(24'($urandom), 1'b1);
        for (int i = 0; i < 6; i++) add_bit(1'($urandom), 1'b1);
        run_range(0, plan.size(), 1'b1);
        model_plan();
        checks++;
        if (pix_mismatch() != 0) begin
            failures++;
            $display("FAIL partial_pixels: got %0d pixels, required %0d", got_pix.size(), exp_pix.size());
        end
        checks++;
        if (got_fpix.size() != 1 || (got_fpix.size() == 1 && (got_fpix[0] != exp_fpix || got_fderr[0] != exp_fderr))) begin
            failures++;
            $display("FAIL partial_frame: got %0d strobes (err same cycle %b), required 1 with %0d pixels and error %b",
                     got_fpix.size(), (got_fderr.size() > 0) ? got_fderr[0] : 1'b0, exp_fpix, exp_fderr);
        end
        checks++;
        if (got_err != exp_err) begin
            failures++;
            $display("FAIL partial_errors: got %0d, required %0d", got_err, exp_err);
        end
    endtask

    task automatic test_long_pulse();
        pulse_t p;
        clear_all();
        for (int i = 0; i < 10; i++) add_bit(1'($urandom), 1'b1);
        p.hi = 30;
        p.lo = 5;
        plan.push_back(p);
        for (int i = 0; i < 14; i++) add_bit(1'($urandom), 1'b1);
        add_pixel(24'($urandom), 1'b1);
        run_range(0, 11, 1'b0);
        checks++;
        if (busy !== 1'b0 || got_err != 1) begin
            failures++;
            $display("FAIL long_pulse_abort: busy=%b errors=%0d, required 0 1", busy, got_err);
        end
        run_range(11, plan.size(), 1'b1);
        model_plan();
        checks++;
        if (got_pix.size() != exp_pix.size() || got_fpix.size() != exp_frames || got_err != exp_err) begin
            failures++;
            $display("FAIL long_pulse_resync: pixels=%0d frames=%0d errors=%0d, required %0d %0d %0d",
                     got_pix.size(), got_fpix.size(), got_err, exp_pix.size(), exp_frames, exp_err);
        end
        clear_all();
        add_pixel(24'h5A3C96, 1'b1);
        run_range(0, plan.size(), 1'b1);
        model_plan();
        checks++;
        if (pix_mismatch() != 0 || got_fpix.size() != exp_frames) begin
            failures++;
            $display("FAIL long_pulse_recover: got %0d pixels %0d frames, required %0d %0d", got_pix.size(), got_fpix.size(), exp_pix.size(), exp_frames);
        end
    endtask

    task automatic test_midstream_reset();
        clear_all();
        add_pixel(24'($urandom), 1'b0);
        run_range(0, 10, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pixel_data !== 24'h0 || frame_pixels !== '0) begin
            failures++;
            $display("FAIL midframe_reset: busy=%b data=%h fpix=%0d, required 0", busy, pixel_data, frame_pixels);
        end
        clear_all();
        add_pixel(24'($urandom), 1'b1);
        add_pixel(24'($urandom), 1'b1);
        run_range(0, 20, 1'b0);
        din = 1'b1;
        rst_n = 1'b1;
        run_range(20, plan.size(), 1'b0);
        checks++;
        if (got_pix.size() != 0 || got_fpix.size() != 0 || got_err != 0) begin
            failures++;
            $display("FAIL midstream_join: pixels=%0d frames=%0d errors=%0d before first latch, required 0", got_pix.size(), got_fpix.size(), got_err);
        end
        drive(1'b0, LC + 20);
        checks++;
        if (got_fpix.size() != 0) begin
            failures++;
            $display("FAIL midstream_latch: %0d frame strobes on sync latch, required 0", got_fpix.size());
        end
        clear_all();
        add_pixel(24'($urandom), 1'b1);
        run_range(0, plan.size(), 1'b1);
        model_plan();
        checks++;
        if (pix_mismatch() != 0 || got_fpix.size() != exp_frames) begin
            failures++;
            $display("FAIL midstream_first_frame: got %0d pixels %0d frames, required %0d %0d", got_pix.size(), got_fpix.size(), exp_pix.size(), exp_frames);
        end
    endtask

    task automatic test_overflow();
        rst_n = 1'b0;
        drive(1'b0, 2);
        rst_n = 1'b1;
        drive(1'b0, LC + 20);
        clear_all();
        for (int p = 0; p < NUM_LEDS + 1; p++) add_pixel(24'($urandom), 1'b0);
        run_range(0, plan.size(), 1'b1);
        model_plan();
        checks++;
        if (pix_mismatch() != 0) begin
            failures++;
            $display("FAIL overflow_pixels: got %0d pixels, %0d mismatched, required %0d", got_pix.size(), pix_mismatch(), exp_pix.size());
        end
        checks++;
        if (got_fpix.size() != 1 || (got_fpix.size() == 1 && got_fpix[0] != exp_fpix)) begin
            failures++;
            $display("FAIL overflow_frame: got %0d strobes (pixels %0d), required 1 with %0d",
                     got_fpix.size(), (got_fpix.size() > 0) ? got_fpix[0] : -1, exp_fpix);
        end
        checks++;
        if (got_err != exp_err) begin
            failures++;
            $display("FAIL overflow_errors: got %0d, required %0d", got_err, exp_err);
        end
`ifdef WS2812_RX_STATS_EN
        checks++;
        if (int'(frame_count) != exp_frames || int'(error_count) != exp_err) begin
            failures++;
            $display("FAIL overflow_stats: frames=%0d errors=%0d, required %0d %0d", frame_count, error_count, exp_frames, exp_err);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_pixel();
        test_three_pixels();
        test_random_frames();
        test_partial_bits();
        test_long_pulse();
        test_midstream_reset();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
